// File: rtl/pmm_pkg.sv
// ============================================================================
// Module      : pmm_pkg
// Description : Shared encodings and helpers for the multi-context PMM engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pmm_pkg;

  typedef enum logic [2:0] {
    SEL_REPPOS  = 3'd0,
    SEL_MOVE    = 3'd1,
    SEL_EPS_BEG = 3'd2,
    SEL_EPS_BLK = 3'd3,
    SEL_EPS_END = 3'd4,
    SEL_INIT    = 3'd5,
    SEL_ACCEPT  = 3'd6,
    SEL_NONE    = 3'd7
  } cfg_sel_e;

  typedef enum logic {
    OP_SCAN = 1'b0,
    OP_CLR  = 1'b1
  } op_e;

  // Context id width, never below one bit so single-context builds still have a port.
  function automatic int ctx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pmm_nfa_step.sv
// ============================================================================
// Module      : pmm_nfa_step
// Description : One combinational step of the extended shift-and NFA.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmm_nfa_step #(
  parameter int STATE_W = 64
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic [STATE_W-1:0] init_i,
  input  logic [STATE_W-1:0] move_i,
  input  logic [STATE_W-1:0] reppos_i,
  input  logic [STATE_W-1:0] eps_beg_i,
  input  logic [STATE_W-1:0] eps_blk_i,
  input  logic [STATE_W-1:0] eps_end_i,
  input  logic [STATE_W-1:0] accept_i,
  output logic [STATE_W-1:0] new_state_o,
  output logic               match_o
);

  logic [STATE_W-1:0] w_tmp;
  logic [STATE_W-1:0] w_high;
  logic [STATE_W-1:0] w_low;

  assign w_tmp  = (((state_i << 1) | init_i) & move_i) | (state_i & reppos_i);
  // The subtraction ripples a borrow through each epsilon block, filling it.
  assign w_high = w_tmp | eps_end_i;
  assign w_low  = w_high - eps_beg_i;

  assign new_state_o = (eps_blk_i & (~w_low ^ w_high)) | w_tmp;
  assign match_o     = |(new_state_o & accept_i);

endmodule

`default_nettype wire

// File: rtl/pmm_mctx_engine.sv
// ============================================================================
// Module      : pmm_mctx_engine
// Description : Two-stage multi-context shift-and NFA matcher, one char/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmm_mctx_engine
  import pmm_pkg::*;
#(
  parameter int STATE_W = 64,
  parameter int CHAR_W  = 8,
  parameter int NUM_CTX = 4,
  parameter int POS_W   = 32,
  localparam int CTX_W  = ctx_w(NUM_CTX)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [2:0]         cfg_sel_i,
  input  logic [CHAR_W-1:0]  cfg_idx_i,
  input  logic [STATE_W-1:0] cfg_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_op_i,
  input  logic [CTX_W-1:0]   in_ctx_i,
  input  logic [CHAR_W-1:0]  in_char_i,
  output logic               out_valid_o,
  output logic [CTX_W-1:0]   out_ctx_o,
  output logic               out_match_o,
  output logic [POS_W-1:0]   out_pos_o,
  output logic [STATE_W-1:0] out_state_o
);

  localparam int DEPTH = 2 ** CHAR_W;

  logic               rel_q;
  logic               s1_valid_q;
  op_e                s1_op_q;
  logic [CTX_W-1:0]   s1_ctx_q;
  logic [STATE_W-1:0] rd_reppos_q, rd_move_q;
  logic [STATE_W-1:0] eps_beg_q, eps_blk_q, eps_end_q, init_q, accept_q;
  logic [STATE_W-1:0] state_q [NUM_CTX];
  logic [POS_W-1:0]   pos_q   [NUM_CTX];
  logic [STATE_W-1:0] reppos_mem [DEPTH];
  logic [STATE_W-1:0] move_mem   [DEPTH];

  logic               out_valid_q, out_match_q;
  logic [CTX_W-1:0]   out_ctx_q;
  logic [POS_W-1:0]   out_pos_q;
  logic [STATE_W-1:0] out_state_q;

  logic               w_in_fire, w_cfg_fire, w_ctx_ok, w_s2_fire, w_match;
  logic [STATE_W-1:0] w_cur_state, w_new_state;
  logic [POS_W-1:0]   w_cur_pos;

  // Config wins the port; it waits only for stage 1 so table reads stay coherent.
  assign in_ready_o  = rel_q & ~cfg_valid_i;
  assign cfg_ready_o = rel_q & cfg_valid_i & ~s1_valid_q;
  assign w_in_fire   = in_valid_i & in_ready_o;
  assign w_cfg_fire  = cfg_ready_o;

  always_ff @(posedge clk_i) begin
    if (w_cfg_fire && cfg_sel_i == SEL_REPPOS) reppos_mem[cfg_idx_i] <= cfg_data_i;
    if (w_cfg_fire && cfg_sel_i == SEL_MOVE)   move_mem[cfg_idx_i]   <= cfg_data_i;
    if (w_in_fire) begin
      rd_reppos_q <= reppos_mem[in_char_i];
      rd_move_q   <= move_mem[in_char_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rel_q     <= 1'b0;
      eps_beg_q <= '0;
      eps_blk_q <= '0;
      eps_end_q <= '0;
      init_q    <= '0;
      accept_q  <= '0;
    end else begin
      rel_q <= 1'b1;
      if (w_cfg_fire) begin
        case (cfg_sel_e'(cfg_sel_i))
          SEL_EPS_BEG: eps_beg_q <= cfg_data_i;
          SEL_EPS_BLK: eps_blk_q <= cfg_data_i;
          SEL_EPS_END: eps_end_q <= cfg_data_i;
          SEL_INIT:    init_q    <= cfg_data_i;
          SEL_ACCEPT:  accept_q  <= cfg_data_i;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_SCAN;
      s1_ctx_q   <= '0;
    end else begin
      s1_valid_q <= w_in_fire;
      if (w_in_fire) begin
        s1_op_q  <= op_e'(in_op_i);
        s1_ctx_q <= in_ctx_i;
      end
    end
  end

  if (NUM_CTX == 2 ** CTX_W) begin : g_ctx_full
    assign w_ctx_ok = 1'b1;
  end else begin : g_ctx_part
    assign w_ctx_ok = {1'b0, s1_ctx_q} < (CTX_W + 1)'(NUM_CTX);
  end

  assign w_s2_fire = s1_valid_q & w_ctx_ok;

  always_comb begin
    w_cur_state = '0;
    w_cur_pos   = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (s1_ctx_q == CTX_W'(i)) begin
        w_cur_state = state_q[i];
        w_cur_pos   = pos_q[i];
      end
    end
  end

  pmm_nfa_step #(.STATE_W(STATE_W)) u_step (
    .state_i     (w_cur_state),
    .init_i      (init_q),
    .move_i      (rd_move_q),
    .reppos_i    (rd_reppos_q),
    .eps_beg_i   (eps_beg_q),
    .eps_blk_i   (eps_blk_q),
    .eps_end_i   (eps_end_q),
    .accept_i    (accept_q),
    .new_state_o (w_new_state),
    .match_o     (w_match)
  );

  // The context update lands one edge before the next item reads it, so no bypass.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        state_q[i] <= '0;
        pos_q[i]   <= '0;
      end
    end else if (w_s2_fire) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (s1_ctx_q == CTX_W'(i)) begin
          if (s1_op_q == OP_CLR) begin
            state_q[i] <= '0;
            pos_q[i]   <= '0;
          end else begin
            state_q[i] <= w_new_state;
            pos_q[i]   <= pos_q[i] + POS_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_ctx_q   <= '0;
      out_match_q <= 1'b0;
      out_pos_q   <= '0;
      out_state_q <= '0;
    end else begin
      out_valid_q <= w_s2_fire & (s1_op_q == OP_SCAN);
      if (w_s2_fire && s1_op_q == OP_SCAN) begin
        out_ctx_q   <= s1_ctx_q;
        out_match_q <= w_match;
        out_pos_q   <= w_cur_pos;
        out_state_q <= w_new_state;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_ctx_o   = out_ctx_q;
  assign out_match_o = out_match_q;
  assign out_pos_o   = out_pos_q;
  assign out_state_o = out_state_q;

endmodule

`default_nettype wire

// File: tb/tb_pmm_mctx_engine.sv
// ============================================================================
// Module      : tb_pmm_mctx_engine
// Description : Directed and randomised self-checking bench for pmm_mctx_engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmm_mctx_engine;
  import pmm_pkg::*;

  typedef struct packed {
    logic [1:0]  ctx;
    logic        m;
    logic [31:0] pos;
    logic [63:0] st;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_sel = '0;
  logic [7:0]  cfg_idx = '0;
  logic [63:0] cfg_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_op = 1'b0;
  logic [1:0]  in_ctx = '0;
  logic [7:0]  in_char = '0;
  logic        out_valid;
  logic [1:0]  out_ctx;
  logic        out_match;
  logic [31:0] out_pos;
  logic [63:0] out_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] m_state, m_init, m_move, m_rp, m_eb, m_ek, m_ee, m_acc, m_new;
  logic        m_match;
  logic [63:0] mv_m [256];
  logic [63:0] rp_m [256];
  logic [63:0] st_m [4];
  logic [31:0] pos_m [4];
  res_t        q [$];

  always #5 clk = ~clk;

  pmm_mctx_engine dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_sel_i(cfg_sel),
    .cfg_idx_i(cfg_idx), .cfg_data_i(cfg_data),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op),
    .in_ctx_i(in_ctx), .in_char_i(in_char),
    .out_valid_o(out_valid), .out_ctx_o(out_ctx), .out_match_o(out_match),
    .out_pos_o(out_pos), .out_state_o(out_state)
  );

  pmm_nfa_step #(.STATE_W(64)) u_model (
    .state_i(m_state), .init_i(m_init), .move_i(m_move), .reppos_i(m_rp),
    .eps_beg_i(m_eb), .eps_blk_i(m_ek), .eps_end_i(m_ee), .accept_i(m_acc),
    .new_state_o(m_new), .match_o(m_match)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_res(input string tag, input logic [1:0] c, input logic m,
                         input logic [31:0] p, input logic [63:0] s);
    chk(tag, {out_valid, out_ctx, out_match, out_pos, out_state}, {1'b1, c, m, p, s});
  endtask

  task automatic cfg_wr(input logic [2:0] sel, input logic [7:0] idx, input logic [63:0] data);
    int t;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_data = data;
    t = 0;
    while (!cfg_ready && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (t >= 8) chk("cfg_timeout", {31'd0, cfg_ready}, 1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  // Returns at the negedge on which the item's result is visible.
  task automatic scan(input logic op, input logic [1:0] c, input logic [7:0] ch);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_ctx = c; in_char = ch;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic pop_check();
    res_t r;
    if (q.size() == 0) begin
      chk("rand_extra", {127'd0, out_valid}, 0);
    end else begin
      r = q.pop_front();
      chk("rand_res", {out_ctx, out_match, out_pos, out_state}, r);
    end
  endtask

  initial begin
    logic [1:0] c;
    logic [7:0] ch;
    logic       op;

    // Reset values
    #1;
    chk("rst_outs", {out_valid, in_ready, cfg_ready, out_ctx, out_match}, 0);
    chk("rst_data", {out_pos, out_state}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {127'd0, in_ready}, 1);

    // Literal "ab"
    cfg_wr(SEL_MOVE,   8'h61, 64'h1);
    cfg_wr(SEL_MOVE,   8'h62, 64'h2);
    cfg_wr(SEL_REPPOS, 8'h61, 64'h0);
    cfg_wr(SEL_REPPOS, 8'h62, 64'h0);
    cfg_wr(SEL_INIT,   8'h00, 64'h1);
    cfg_wr(SEL_ACCEPT, 8'h00, 64'h2);
    scan(OP_SCAN, 2'd0, 8'h61);
    chk_res("ab_a", 2'd0, 1'b0, 32'd0, 64'h1);
    scan(OP_SCAN, 2'd0, 8'h62);
    chk_res("ab_b", 2'd0, 1'b1, 32'd1, 64'h2);

    // Back-to-back interleave, including same-context dependency
    scan(OP_CLR, 2'd0, 8'h00);
    chk("clr_no_out", {127'd0, out_valid}, 0);
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_SCAN; in_ctx = 2'd0; in_char = 8'h61;
    @(negedge clk);
    chk("il_lat", {127'd0, out_valid}, 0);
    in_ctx = 2'd1; in_char = 8'h62;
    @(negedge clk);
    chk_res("il_0", 2'd0, 1'b0, 32'd0, 64'h1);
    in_ctx = 2'd0; in_char = 8'h62;
    @(negedge clk);
    chk_res("il_1", 2'd1, 1'b0, 32'd0, 64'h0);
    in_valid = 1'b0;
    @(negedge clk);
    chk_res("il_2", 2'd0, 1'b1, 32'd1, 64'h2);
    @(negedge clk);
    chk("il_idle", {127'd0, out_valid}, 0);

    // CLR restarts position
    scan(OP_CLR, 2'd0, 8'h00);
    scan(OP_SCAN, 2'd0, 8'h61);
    chk_res("clr_pos", 2'd0, 1'b0, 32'd0, 64'h1);

    // Self-loop "a+b"
    cfg_wr(SEL_REPPOS, 8'h61, 64'h1);
    scan(OP_CLR, 2'd1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      scan(OP_SCAN, 2'd1, (i == 3) ? 8'h62 : 8'h61);
      chk_res("loop", 2'd1, (i == 3), i[31:0], (i == 3) ? 64'h2 : 64'h1);
    end

    // Epsilon block
    cfg_wr(SEL_EPS_BEG, 8'h00, 64'h1);
    cfg_wr(SEL_EPS_END, 8'h00, 64'h4);
    cfg_wr(SEL_EPS_BLK, 8'h00, 64'h6);
    cfg_wr(SEL_ACCEPT,  8'h00, 64'h4);
    cfg_wr(3'd7,        8'h00, 64'hFFFF);
    scan(OP_CLR, 2'd0, 8'h00);
    scan(OP_SCAN, 2'd0, 8'h61);
    chk_res("eps", 2'd0, 1'b1, 32'd0, 64'h7);

    // Config arriving with a SCAN in stage 1
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_SCAN; in_ctx = 2'd3; in_char = 8'h61;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_valid = 1'b1; cfg_sel = SEL_ACCEPT; cfg_data = 64'h8;
    #1;
    chk("cfg_in_ready", {127'd0, in_ready}, 0);
    chk("cfg_blocked", {127'd0, cfg_ready}, 0);
    @(negedge clk);
    chk_res("cfg_old_mask", 2'd3, 1'b1, 32'd0, 64'h7);
    chk("cfg_granted", {127'd0, cfg_ready}, 1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    scan(OP_SCAN, 2'd3, 8'h61);
    chk_res("cfg_new_mask", 2'd3, 1'b0, 32'd1, 64'h7);

    // Reset with items in both stages
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_SCAN; in_ctx = 2'd0; in_char = 8'h61;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_outs", {out_valid, in_ready, cfg_ready, out_ctx, out_match}, 0);
    chk("arst_data", {out_pos, out_state}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_drop", {127'd0, out_valid}, 0);
    end
    cfg_wr(SEL_INIT,   8'h00, 64'h1);
    cfg_wr(SEL_ACCEPT, 8'h00, 64'h2);
    scan(OP_SCAN, 2'd0, 8'h61);
    chk_res("arst_ctx0", 2'd0, 1'b0, 32'd0, 64'h1);
    scan(OP_SCAN, 2'd3, 8'h62);
    chk_res("arst_ctx3", 2'd3, 1'b0, 32'd0, 64'h0);

    // Random masks against the golden step
    for (int i = 0; i < 256; i++) begin
      mv_m[i] = rnd64() & rnd64();
      rp_m[i] = rnd64() & rnd64() & rnd64();
      cfg_wr(SEL_MOVE,   i[7:0], mv_m[i]);
      cfg_wr(SEL_REPPOS, i[7:0], rp_m[i]);
    end
    m_init = rnd64() & rnd64();
    m_eb   = rnd64() & rnd64() & rnd64();
    m_ee   = rnd64() & rnd64() & rnd64();
    m_ek   = rnd64();
    m_acc  = rnd64() & rnd64() & rnd64();
    cfg_wr(SEL_INIT,    8'h00, m_init);
    cfg_wr(SEL_EPS_BEG, 8'h00, m_eb);
    cfg_wr(SEL_EPS_END, 8'h00, m_ee);
    cfg_wr(SEL_EPS_BLK, 8'h00, m_ek);
    cfg_wr(SEL_ACCEPT,  8'h00, m_acc);
    for (int k = 0; k < 4; k++) begin
      scan(OP_CLR, k[1:0], 8'h00);
      st_m[k]  = '0;
      pos_m[k] = '0;
    end

    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (out_valid) pop_check();
      c  = 2'($urandom_range(0, 3));
      ch = 8'($urandom_range(0, 255));
      op = ($urandom_range(0, 63) == 0);
      if (op) begin
        st_m[c]  = '0;
        pos_m[c] = '0;
      end else begin
        m_state = st_m[c];
        m_move  = mv_m[ch];
        m_rp    = rp_m[ch];
        #1;
        q.push_back('{ctx: c, m: m_match, pos: pos_m[c], st: m_new});
        st_m[c]  = m_new;
        pos_m[c] = pos_m[c] + 32'd1;
      end
      in_valid = 1'b1; in_op = op; in_ctx = c; in_char = ch;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      if (out_valid) pop_check();
    end
    chk("rand_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
